// File: rtl/lab2_proc_imul_div_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding, FSM states
// and the value returned for the reserved op.
package lab2_proc_imul_div_pkg;

    typedef enum logic [2:0] {
        OP_MUL   = 3'd0,
        OP_MULH  = 3'd1,
        OP_MULHU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_REM   = 3'd5,
        OP_REMU  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Every bit of the reserved-op result takes this value.
    localparam logic RSVD_RESULT_BIT = 1'b0;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/lab2_proc_imul_div_iter_if.sv
// Request/response stream bundle for the iterative multiply/divide unit.
interface lab2_proc_imul_div_iter_if #(
    parameter int p_nbits    = 32,
    parameter int p_tag_bits = 5
);
    logic                  istream_val;
    logic                  istream_rdy;
    logic [2:0]            istream_msg_op;
    logic [p_nbits-1:0]    istream_msg_a;
    logic [p_nbits-1:0]    istream_msg_b;
    logic [p_tag_bits-1:0] istream_msg_tag;
    logic                  flush;
    logic                  ostream_val;
    logic                  ostream_rdy;
    logic [p_nbits-1:0]    ostream_msg_result;
    logic [p_tag_bits-1:0] ostream_msg_tag;

    modport master (
        output istream_val, istream_msg_op, istream_msg_a, istream_msg_b, istream_msg_tag,
        output flush, ostream_rdy,
        input  istream_rdy, ostream_val, ostream_msg_result, ostream_msg_tag
    );

    modport slave (
        input  istream_val, istream_msg_op, istream_msg_a, istream_msg_b, istream_msg_tag,
        input  flush, ostream_rdy,
        output istream_rdy, ostream_val, ostream_msg_result, ostream_msg_tag
    );
endinterface

// File: rtl/lab2_proc_imul_div_iter_dpath.sv
// Datapath: operand/product registers, shared add/subtract step, sign fix-up
// and result selection. The product register doubles as {remainder, quotient}.
module lab2_proc_imul_div_iter_dpath
    import lab2_proc_imul_div_pkg::*;
#(
    parameter int p_nbits    = 32,
    parameter int p_tag_bits = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic                  last,
    input  logic [2:0]            op_in,
    input  logic [p_nbits-1:0]    a_in,
    input  logic [p_nbits-1:0]    b_in,
    input  logic [p_tag_bits-1:0] tag_in,
    output logic [p_nbits-1:0]    result,
    output logic [p_tag_bits-1:0] tag
);
    localparam int N = p_nbits;

    op_e                   op_r;
    logic [N-1:0]          opnd_r;
    logic [2*N-1:0]        prod_r;
    logic                  neg_hi_r;
    logic                  neg_lo_r;
    logic                  bzero_r;
    logic [N-1:0]          result_r;
    logic [p_tag_bits-1:0] tag_r;

    op_e            op_in_s;
    logic           sgn_s;
    logic           a_neg_s;
    logic           b_neg_s;
    logic [N-1:0]   a_mag_s;
    logic [N-1:0]   b_mag_s;
    logic           is_div_s;
    logic [N:0]     x_s;
    logic [N:0]     y_s;
    logic [N+1:0]   sum_s;
    logic [2*N-1:0] prod_nxt_s;
    logic [2*N-1:0] prod_neg_s;
    logic [N-1:0]   hi_s;
    logic [N-1:0]   lo_s;
    logic [N-1:0]   result_nxt_s;

    // Operand conditioning: signed ops work on magnitudes.
    always_comb begin
        op_in_s = op_e'(op_in);
        sgn_s   = op_is_signed(op_in_s);
        a_neg_s = sgn_s & a_in[N-1];
        b_neg_s = sgn_s & b_in[N-1];
        a_mag_s = a_neg_s ? -a_in : a_in;
        b_mag_s = b_neg_s ? -b_in : b_in;
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        is_div_s = op_is_div(op_r);
        if (is_div_s) begin
            x_s = prod_r[2*N-1:N-1];
        end else begin
            x_s = {1'b0, prod_r[2*N-1:N]};
        end
        if (is_div_s || prod_r[0]) begin
            y_s = {1'b0, opnd_r};
        end else begin
            y_s = '0;
        end
        if (is_div_s) begin
            sum_s = {1'b0, x_s} - {1'b0, y_s};
        end else begin
            sum_s = {1'b0, x_s} + {1'b0, y_s};
        end
        if (!is_div_s) begin
            prod_nxt_s = {sum_s[N:0], prod_r[N-1:1]};
        end else if (sum_s[N+1]) begin
            prod_nxt_s = {x_s[N-1:0], prod_r[N-2:0], 1'b0};
        end else begin
            prod_nxt_s = {sum_s[N-1:0], prod_r[N-2:0], 1'b1};
        end
        prod_neg_s = -prod_nxt_s;
        hi_s       = prod_nxt_s[2*N-1:N];
        lo_s       = prod_nxt_s[N-1:0];
    end

    // Sign fix-up and result select, applied to the final iteration's value.
    // A zero divisor leaves an all-ones quotient that must not be negated.
    always_comb begin
        case (op_r)
            OP_MUL:   result_nxt_s = lo_s;
            OP_MULH:  result_nxt_s = neg_hi_r ? prod_neg_s[2*N-1:N] : hi_s;
            OP_MULHU: result_nxt_s = hi_s;
            OP_DIV:   result_nxt_s = (neg_hi_r && !bzero_r) ? prod_neg_s[N-1:0] : lo_s;
            OP_DIVU:  result_nxt_s = lo_s;
            OP_REM:   result_nxt_s = neg_lo_r ? -hi_s : hi_s;
            OP_REMU:  result_nxt_s = hi_s;
            default:  result_nxt_s = {N{RSVD_RESULT_BIT}};
        endcase
    end

    // Operand, product, sign and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r     <= OP_MUL;
            opnd_r   <= '0;
            prod_r   <= '0;
            neg_hi_r <= 1'b0;
            neg_lo_r <= 1'b0;
            bzero_r  <= 1'b0;
            result_r <= '0;
            tag_r    <= '0;
        end else if (load) begin
            op_r     <= op_in_s;
            opnd_r   <= op_is_div(op_in_s) ? b_mag_s : a_mag_s;
            prod_r   <= {{N{1'b0}}, (op_is_div(op_in_s) ? a_mag_s : b_mag_s)};
            neg_hi_r <= a_neg_s ^ b_neg_s;
            neg_lo_r <= a_neg_s;
            bzero_r  <= (b_in == '0);
            tag_r    <= tag_in;
        end else if (step) begin
            prod_r <= prod_nxt_s;
            if (last) begin
                result_r <= result_nxt_s;
            end
        end
    end

    assign result = result_r;
    assign tag    = tag_r;

endmodule

// File: rtl/lab2_proc_imul_div_iter.sv
// Iterative one-bit-per-cycle multiply/divide unit with a fixed p_nbits+1 cycle
// latency, stream handshakes and a flush that squashes the in-flight op.
module lab2_proc_imul_div_iter
    import lab2_proc_imul_div_pkg::*;
#(
    parameter int p_nbits    = 32,
    parameter int p_tag_bits = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    lab2_proc_imul_div_iter_if.slave    io
);
    localparam int CW = $clog2(p_nbits + 1);

    state_e                state_r;
    state_e                state_nxt_s;
    logic [CW-1:0]         count_r;
    logic                  istream_rdy_s;
    logic                  ostream_val_s;
    logic                  req_fire_s;
    logic                  step_s;
    logic                  last_s;
    logic [p_nbits-1:0]    dp_result_s;
    logic [p_tag_bits-1:0] dp_tag_s;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM outputs: handshakes and datapath strobes.
    always_comb begin
        istream_rdy_s = 1'b0;
        ostream_val_s = 1'b0;
        step_s        = 1'b0;
        case (state_r)
            ST_IDLE: istream_rdy_s = !io.flush;
            ST_CALC: step_s = 1'b1;
            ST_DONE: begin
                ostream_val_s = 1'b1;
                istream_rdy_s = !io.flush && io.ostream_rdy;
            end
            default: istream_rdy_s = 1'b0;
        endcase
        req_fire_s = io.istream_val && istream_rdy_s;
        last_s     = (count_r == CW'(1));
    end

    // FSM next state; flush overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        if (io.flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_fire_s) begin
                        state_nxt_s = ST_CALC;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (io.ostream_rdy) begin
                        state_nxt_s = req_fire_s ? ST_CALC : ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Iteration counter: loaded on accept, counts CALC cycles down to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (io.flush) begin
            count_r <= '0;
        end else if (req_fire_s) begin
            count_r <= CW'(p_nbits);
        end else if (state_r == ST_CALC) begin
            count_r <= count_r - CW'(1);
        end
    end

    lab2_proc_imul_div_iter_dpath #(
        .p_nbits    (p_nbits),
        .p_tag_bits (p_tag_bits)
    ) u_dpath (
        .clk    (clk),
        .reset  (reset),
        .load   (req_fire_s),
        .step   (step_s),
        .last   (last_s),
        .op_in  (io.istream_msg_op),
        .a_in   (io.istream_msg_a),
        .b_in   (io.istream_msg_b),
        .tag_in (io.istream_msg_tag),
        .result (dp_result_s),
        .tag    (dp_tag_s)
    );

    assign io.istream_rdy        = istream_rdy_s;
    assign io.ostream_val        = ostream_val_s;
    assign io.ostream_msg_result = ostream_val_s ? dp_result_s : '0;
    assign io.ostream_msg_tag    = ostream_val_s ? dp_tag_s : '0;

endmodule

// File: tb/tb_lab2_proc_imul_div_iter.sv
// Self-checking bench for lab2_proc_imul_div_iter (p_nbits=32) using a result
// scoreboard and an operator-level reference model.
module tb_lab2_proc_imul_div_iter;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHU = 3'd2, DIV = 3'd3,
                           DIVU = 3'd4, REM = 3'd5, REMU = 3'd6, RSVD = 3'd7;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lab2_proc_imul_div_iter_if #(.p_nbits(32), .p_tag_bits(5)) io ();

    lab2_proc_imul_div_iter #(.p_nbits(32), .p_tag_bits(5)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    localparam logic [2:0]  MC_OP [5] = '{MULH, MULHU, MUL, RSVD, MUL};
    localparam logic [31:0] MC_A  [5] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1234, 32'hFFFFFFFB};
    localparam logic [31:0] MC_B  [5] = '{32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd5678, 32'd3};
    localparam logic [31:0] MC_R  [5] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFF1};

    localparam logic [2:0]  DC_OP [9] = '{DIV, REM, DIV, REMU, DIV, REM, DIVU, REMU, REM};
    localparam logic [31:0] DC_A  [9] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5, 32'h80000000,
                                          32'h80000000, 32'd100, 32'd100, 32'hFFFFFFF9};
    localparam logic [31:0] DC_B  [9] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF,
                                          32'hFFFFFFFF, 32'd7, 32'd7, 32'd0};
    localparam logic [31:0] DC_R  [9] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000,
                                          32'd0, 32'd14, 32'd2, 32'hFFFFFFF9};

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sbv;
        logic [63:0] p;
        logic [31:0] r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        p   = 64'd0;
        case (op)
            MUL:   begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            MULH:  begin p = sa * sbv; r = p[63:32]; end
            MULHU: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            DIV:   begin
                if (b == 32'd0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                else begin p = sa / sbv; r = p[31:0]; end
            end
            DIVU:  r = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            REM:   begin
                if (b == 32'd0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
                else begin p = sa % sbv; r = p[31:0]; end
            end
            REMU:  r = (b == 32'd0) ? a : a % b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output bit acc, output int t);
        io.istream_val     = 1'b1;
        io.istream_msg_op  = op;
        io.istream_msg_a   = a;
        io.istream_msg_b   = b;
        io.istream_msg_tag = tag;
        #1;
        acc = io.istream_rdy;
        t   = cyc;
        @(posedge clk); #1;
        io.istream_val = 1'b0;
    endtask

    task automatic wait_val(output int seen, output bit to);
        to   = 1'b1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (io.ostream_val === 1'b1) begin
                seen = cyc;
                to   = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        if (to) begin
            total_cnt++;
            $display("FAIL wait_val: ostream_val not seen within 100 cycles");
        end
    endtask

    task automatic recv(output logic [31:0] r, output logic [4:0] tg, output exp_t e, output int seen);
        bit to;
        wait_val(seen, to);
        r  = io.ostream_msg_result;
        tg = io.ostream_msg_tag;
        if (sb.size() > 0) e = sb.pop_front();
        else e = 'x;
        if (!to) begin
            io.ostream_rdy = 1'b1;
            @(posedge clk); #1;
            io.ostream_rdy = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        io.istream_val = 1'b0; io.istream_msg_op = 3'd0; io.istream_msg_a = 32'd0;
        io.istream_msg_b = 32'd0; io.istream_msg_tag = 5'd0; io.flush = 1'b0; io.ostream_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (io.ostream_val !== 1'b0) $display("FAIL reset_val: got %b expected 0", io.ostream_val);
        else pass_cnt++;
        total_cnt++;
        if (io.ostream_msg_result !== 32'd0) $display("FAIL reset_result: got %h expected 0", io.ostream_msg_result);
        else pass_cnt++;
        total_cnt++;
        if (io.ostream_msg_tag !== 5'd0) $display("FAIL reset_tag: got %h expected 0", io.ostream_msg_tag);
        else pass_cnt++;
        total_cnt++;
        if (io.istream_rdy !== 1'b1) $display("FAIL reset_rdy: got %b expected 1", io.istream_rdy);
        else pass_cnt++;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_basic();
        bit acc; int t; int seen; logic [31:0] r; logic [4:0] tg; exp_t e;
        send(MUL, 32'd7, 32'd6, 5'd3, acc, t);
        sb.push_back('{res: 32'd42, tag: 5'd3});
        total_cnt++;
        if (acc !== 1'b1) $display("FAIL mul_basic_accept: got %b expected 1", acc);
        else pass_cnt++;
        recv(r, tg, e, seen);
        total_cnt++;
        if (seen !== t + 33) $display("FAIL mul_basic_latency: got cycle %0d expected %0d", seen, t + 33);
        else pass_cnt++;
        total_cnt++;
        if (r !== e.res) $display("FAIL mul_basic_result: got %h expected %h", r, e.res);
        else pass_cnt++;
        total_cnt++;
        if (tg !== e.tag) $display("FAIL mul_basic_tag: got %h expected %h", tg, e.tag);
        else pass_cnt++;
    endtask

    task automatic test_table(input bit is_div);
        bit acc; int t; int seen; logic [31:0] r; logic [4:0] tg; exp_t e;
        int n;
        logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] x;
        n = is_div ? 9 : 5;
        for (int i = 0; i < n; i++) begin
            op = is_div ? DC_OP[i] : MC_OP[i];
            a  = is_div ? DC_A[i]  : MC_A[i];
            b  = is_div ? DC_B[i]  : MC_B[i];
            x  = is_div ? DC_R[i]  : MC_R[i];
            send(op, a, b, 5'(i + 10), acc, t);
            sb.push_back('{res: x, tag: 5'(i + 10)});
            recv(r, tg, e, seen);
            total_cnt++;
            if (r !== e.res || tg !== e.tag)
                $display("FAIL %s_case%0d: got %h/%h expected %h/%h", is_div ? "div" : "mul", i, r, tg, e.res, e.tag);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        bit acc; int t; int seen; logic [31:0] r; logic [4:0] tg; exp_t e;
        logic [2:0] op; logic [31:0] a; logic [31:0] b;
        for (int i = 0; i < 14; i++) begin
            op = 3'(i % 7);
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i % 5 == 4) a = -a;
            send(op, a, b, 5'(i), acc, t);
            sb.push_back('{res: model(op, a, b), tag: 5'(i)});
            recv(r, tg, e, seen);
            total_cnt++;
            if (r !== e.res || tg !== e.tag)
                $display("FAIL random%0d op%0d a=%h b=%h: got %h/%h expected %h/%h", i, op, a, b, r, tg, e.res, e.tag);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        bit acc; int t; int seen; bit to; logic [31:0] r0; logic [4:0] t0;
        logic [31:0] r; logic [4:0] tg; exp_t e;
        send(MULHU, 32'h12345678, 32'h9ABCDEF0, 5'd21, acc, t);
        sb.push_back('{res: model(MULHU, 32'h12345678, 32'h9ABCDEF0), tag: 5'd21});
        wait_val(seen, to);
        r0 = io.ostream_msg_result;
        t0 = io.ostream_msg_tag;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (io.ostream_val !== 1'b1 || io.ostream_msg_result !== r0 || io.ostream_msg_tag !== t0 || io.istream_rdy !== 1'b0)
                $display("FAIL backpressure_hold%0d: got val=%b res=%h tag=%h rdy=%b expected 1/%h/%h/0",
                         i, io.ostream_val, io.ostream_msg_result, io.ostream_msg_tag, io.istream_rdy, r0, t0);
            else pass_cnt++;
        end
        e = sb.pop_front();
        total_cnt++;
        if (r0 !== e.res || t0 !== e.tag) $display("FAIL backpressure_result: got %h/%h expected %h/%h", r0, t0, e.res, e.tag);
        else pass_cnt++;
        io.ostream_rdy = 1'b1;
        send(DIVU, 32'd1000, 32'd33, 5'd22, acc, t);
        io.ostream_rdy = 1'b0;
        sb.push_back('{res: 32'd30, tag: 5'd22});
        total_cnt++;
        if (acc !== 1'b1) $display("FAIL b2b_accept: got %b expected 1", acc);
        else pass_cnt++;
        total_cnt++;
        if (io.ostream_val !== 1'b0) $display("FAIL b2b_val_after: got %b expected 0", io.ostream_val);
        else pass_cnt++;
        recv(r, tg, e, seen);
        total_cnt++;
        if (seen !== t + 33) $display("FAIL b2b_latency: got cycle %0d expected %0d", seen, t + 33);
        else pass_cnt++;
        total_cnt++;
        if (r !== e.res || tg !== e.tag) $display("FAIL b2b_result: got %h/%h expected %h/%h", r, tg, e.res, e.tag);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        bit acc; int t; int seen; bit leak; logic [31:0] r; logic [4:0] tg; exp_t e;
        send(MUL, 32'd11, 32'd13, 5'd9, acc, t);
        repeat (9) begin @(posedge clk); #1; end
        io.flush = 1'b1;
        io.istream_val = 1'b1; io.istream_msg_op = MUL; io.istream_msg_a = 32'd2;
        io.istream_msg_b = 32'd2; io.istream_msg_tag = 5'd1;
        #1;
        total_cnt++;
        if (io.istream_rdy !== 1'b0) $display("FAIL flush_rdy_low: got %b expected 0", io.istream_rdy);
        else pass_cnt++;
        @(posedge clk); #1;
        io.flush = 1'b0;
        io.istream_val = 1'b0;
        #1;
        total_cnt++;
        if (io.istream_rdy !== 1'b1) $display("FAIL flush_rdy_next: got %b expected 1", io.istream_rdy);
        else pass_cnt++;
        leak = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (io.ostream_val === 1'b1) leak = 1'b1;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (leak !== 1'b0) $display("FAIL flush_squash: got ostream_val=1 expected none");
        else pass_cnt++;
        send(MUL, 32'd3, 32'd3, 5'd4, acc, t);
        sb.push_back('{res: 32'd9, tag: 5'd4});
        recv(r, tg, e, seen);
        total_cnt++;
        if (r !== e.res || tg !== e.tag) $display("FAIL flush_after: got %h/%h expected %h/%h", r, tg, e.res, e.tag);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        bit acc; int t; int seen; bit to; logic [31:0] r; logic [4:0] tg; exp_t e;
        send(MUL, 32'd5, 32'd5, 5'd2, acc, t);
        repeat (4) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if (io.ostream_val !== 1'b0 || io.istream_rdy !== 1'b1)
            $display("FAIL reset_calc: got val=%b rdy=%b expected 0/1", io.ostream_val, io.istream_rdy);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (io.istream_rdy !== 1'b1) $display("FAIL reset_release_rdy: got %b expected 1", io.istream_rdy);
        else pass_cnt++;
        send(MUL, 32'd6, 32'd7, 5'd6, acc, t);
        wait_val(seen, to);
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if (io.ostream_val !== 1'b0 || io.ostream_msg_result !== 32'd0 || io.ostream_msg_tag !== 5'd0)
            $display("FAIL reset_done: got %b/%h/%h expected 0/0/0", io.ostream_val, io.ostream_msg_result, io.ostream_msg_tag);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b1;
        send(MUL, 32'd3, 32'd5, 5'd7, acc, t);
        sb.push_back('{res: 32'd15, tag: 5'd7});
        recv(r, tg, e, seen);
        total_cnt++;
        if (r !== e.res || tg !== e.tag) $display("FAIL reset_recover: got %h/%h expected %h/%h", r, tg, e.res, e.tag);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_table(1'b0);
        test_table(1'b1);
        test_random();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
